// File: rtl/uart_rx_oversampler.sv
// UART receiver: oversampled start detection, mid-bit data sampling,
// optional parity check and stop-bit validation with one-cycle status pulses.
module uart_rx_oversampler #(
    parameter int DATA_BITS  = 8,
    parameter int SAMPLE     = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_clk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 busy
);

    localparam int CW = $clog2(SAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(SAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);
    localparam logic          PAR_ON   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic                 sclk_q;
    logic [CW-1:0]        count_q, count_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 tick;

    // Either edge of the generator's level-toggling clock counts as one tick.
    assign tick = sclk_q ^ sample_clk;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            sclk_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            sclk_q    <= sample_clk;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            rx_data_q <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            rx_data_q <= rx_data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        rx_data_d = rx_data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;

        if (tick) begin
            count_d = count_q + CW'(1);
            case (state_q)
                IDLE: begin
                    count_d = '0;
                    if (!rx_s_q) begin
                        state_d   = START;
                        bit_cnt_d = '0;
                        par_bad_d = 1'b0;
                    end
                end
                START: begin
                    if (count_q == CNT_HALF) begin
                        count_d = '0;
                        state_d = rx_s_q ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (count_q == CNT_LAST) begin
                        count_d   = '0;
                        shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = PAR_ON ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (count_q == CNT_LAST) begin
                        count_d   = '0;
                        par_bad_d = ((^shift_q) ^ rx_s_q) != ODD;
                        state_d   = STOP;
                    end
                end
                STOP: begin
                    if (count_q == CNT_LAST) begin
                        count_d = '0;
                        state_d = IDLE;
                        if (rx_s_q) begin
                            rx_data_d = shift_q;
                            valid_d   = 1'b1;
                            perr_d    = par_bad_q;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = valid_q;
    assign frame_error  = ferr_q;
    assign parity_error = perr_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Scoreboard bench: stimulus pushes expected status events, monitors pop and
// compare on every status pulse of either receiver instance.
module tb_uart_rx_oversampler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_clk = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic [7:0] rx_data0, rx_data1;
    logic       valid0, ferr0, perr0, busy0;
    logic       valid1, ferr1, perr1, busy1;

    typedef struct packed {
        logic       v;
        logic       fe;
        logic       pe;
        logic [7:0] d;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    uart_rx_oversampler #(
        .DATA_BITS(8), .SAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)
    ) u_dut (
        .clk(clk), .reset(reset), .sample_clk(sample_clk), .rx(rx0),
        .rx_data(rx_data0), .rx_valid(valid0), .frame_error(ferr0),
        .parity_error(perr0), .busy(busy0)
    );

    uart_rx_oversampler #(
        .DATA_BITS(8), .SAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)
    ) u_par (
        .clk(clk), .reset(reset), .sample_clk(sample_clk), .rx(rx1),
        .rx_data(rx_data1), .rx_valid(valid1), .frame_error(ferr1),
        .parity_error(perr1), .busy(busy1)
    );

    // sample_clk toggles every clk, so every clk cycle is a tick.
    initial begin
        forever begin
            #5 clk = 1'b1;
            #5 clk = 1'b0;
            sample_clk = ~sample_clk;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid0 || ferr0 || perr0) begin
            if (q0.size() == 0) begin
                check("dut0 unexpected pulse", {29'd0, valid0, ferr0, perr0}, 32'd0);
            end else begin
                e = q0.pop_front();
                check("dut0 flags v/fe/pe", {29'd0, valid0, ferr0, perr0}, {29'd0, e.v, e.fe, e.pe});
                check("dut0 rx_data", {24'd0, rx_data0}, {24'd0, e.d});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (valid1 || ferr1 || perr1) begin
            if (q1.size() == 0) begin
                check("dut1 unexpected pulse", {29'd0, valid1, ferr1, perr1}, 32'd0);
            end else begin
                e = q1.pop_front();
                check("dut1 flags v/fe/pe", {29'd0, valid1, ferr1, perr1}, {29'd0, e.v, e.fe, e.pe});
                check("dut1 rx_data", {24'd0, rx_data1}, {24'd0, e.d});
            end
        end
    end

    task automatic drive_bit(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx1 = v;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input logic [7:0] data, input logic par_en,
                              input logic par_bit, input logic stop_bit);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, data[i]);
        if (par_en) drive_bit(which, par_bit);
        drive_bit(which, stop_bit);
    endtask

    initial begin
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("reset rx_data0", {24'd0, rx_data0}, 32'd0);
        check("reset status0", {28'd0, valid0, ferr0, perr0, busy0}, 32'd0);
        check("reset rx_data1", {24'd0, rx_data1}, 32'd0);
        check("reset status1", {28'd0, valid1, ferr1, perr1, busy1}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 frame 0xA5
        q0.push_back('{v: 1'b1, fe: 1'b0, pe: 1'b0, d: 8'hA5});
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);

        // 4-tick low glitch on idle line
        rx0 = 1'b0;
        repeat (4) @(negedge clk);
        rx0 = 1'b1;
        repeat (3) @(negedge clk);
        check("glitch busy high", {31'd0, busy0}, 32'd1);
        repeat (20) @(negedge clk);
        check("glitch busy dropped", {31'd0, busy0}, 32'd0);
        check("glitch rx_data kept", {24'd0, rx_data0}, 32'hA5);

        // stop bit forced low: frame error, data retained
        q0.push_back('{v: 1'b0, fe: 1'b1, pe: 1'b0, d: 8'hA5});
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        rx0 = 1'b1;
        repeat (40) @(negedge clk);
        check("after frame error idle", {31'd0, busy0}, 32'd0);

        // back-to-back frames, single stop bit
        q0.push_back('{v: 1'b1, fe: 1'b0, pe: 1'b0, d: 8'h55});
        q0.push_back('{v: 1'b1, fe: 1'b0, pe: 1'b0, d: 8'hFF});
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);

        // reset after third data bit of 0x81 (LSB first: 1,0,0)
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rx0 = 1'b1;
        repeat (200) @(negedge clk);
        check("mid-frame reset busy", {31'd0, busy0}, 32'd0);
        check("mid-frame reset rx_data", {24'd0, rx_data0}, 32'd0);
        q0.push_back('{v: 1'b1, fe: 1'b0, pe: 1'b0, d: 8'h42});
        send_frame(0, 8'h42, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);

        // even parity: 0x07 needs parity 1, send 0 -> mismatch
        q1.push_back('{v: 1'b1, fe: 1'b0, pe: 1'b1, d: 8'h07});
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        // 0x03 with parity 0 is correct
        q1.push_back('{v: 1'b1, fe: 1'b0, pe: 1'b0, d: 8'h03});
        send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
        repeat (30) @(negedge clk);

        check("dut0 events outstanding", q0.size(), 32'd0);
        check("dut1 events outstanding", q1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampler.md
UART_RX_OVERSAMPLER -- requirements
Module: uart_rx_oversampler

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (5..9).
REQ-002 SHALL have parameter SAMPLE, default 16, meaning sample ticks per bit (even, >=8).
REQ-003 SHALL have parameter PARITY_EN, default 0, meaning 1 = one parity bit follows the data.
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning 1 = odd parity, 0 = even parity.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all logic on posedge clk.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port sample_clk, input, 1 bit: level-toggling oversample clock from the UART clock generator.
REQ-008 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-009 SHALL have port rx_data, output, DATA_BITS bits: last received payload.
REQ-010 SHALL have port rx_valid, output, 1 bit: one-cycle pulse, rx_data updated.
REQ-011 SHALL have port frame_error, output, 1 bit: one-cycle pulse, stop bit sampled low.
REQ-012 SHALL have port parity_error, output, 1 bit: one-cycle pulse, parity mismatch.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer (reset value 1); only the synchronized value (rx_s) is used.
REQ-015 SHALL register sample_clk once; a tick is any cycle where the registered value differs from the current sample_clk (either edge), giving one tick per generator toggle.
REQ-016 SHALL advance tick counter (0..SAMPLE-1) and the FSM only on tick cycles; non-tick cycles hold all state.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE: on a tick with rx_s==0 -> START, tick counter cleared.
REQ-019 START: on tick with count==SAMPLE/2-1, rx_s==0 -> DATA, counter cleared; rx_s==1 -> IDLE (glitch rejected, no output pulse).
REQ-020 DATA: on tick with count==SAMPLE-1, rx_s shifted into MSB of shift register (LSB first on the line), counter cleared, bit counter incremented; after DATA_BITS bits -> PARITY if PARITY_EN else STOP.
REQ-021 PARITY: on tick with count==SAMPLE-1, capture parity bit; error if XOR(data, bit) != PARITY_ODD; -> STOP.
REQ-022 STOP: on tick with count==SAMPLE-1: rx_s==1 -> rx_data loaded, rx_valid pulsed (parity_error pulsed with it on mismatch); rx_s==0 -> frame_error pulsed, rx_data and rx_valid unchanged; -> IDLE either way.
REQ-023 Status pulses SHALL assert in the cycle after the STOP sampling tick, exactly one clk wide.
REQ-024 rx_data SHALL hold its value until the next valid frame.
REQ-025 Back-to-back frames: a start edge on the first tick after STOP→IDLE SHALL be accepted.
REQ-026 rx going high mid-DATA SHALL NOT abort the frame; only the STOP check flags errors.

Reset
REQ-027 reset SHALL force state IDLE, counters 0, shift register 0, rx_data 0, rx_valid/frame_error/parity_error/busy 0, synchronizer flops 1, registered sample_clk 0.
REQ-028 reset asserted mid-frame SHALL discard the partial frame with no status pulse; reception restarts at the next start bit after release.
REQ-029 reset SHALL take priority over tick and rx in the same cycle.

Verification
REQ-030 SAMPLE=16, sample_clk toggled every clk, frame 0xA5 (8N1) -> one rx_valid pulse, rx_data=0xA5, no error pulses.
REQ-031 Low glitch of 4 ticks on idle rx -> FSM returns to IDLE, busy drops, no pulses, rx_data unchanged.
REQ-032 Frame 0x3C with stop bit forced 0 -> frame_error single pulse, rx_valid stays 0, rx_data keeps prior value.
REQ-033 PARITY_EN=1, PARITY_ODD=0, frame 0x07 with parity bit 0 -> rx_valid and parity_error pulse together, rx_data=0x07.
REQ-034 Two frames 0x55, 0xFF back-to-back with single stop bit -> two rx_valid pulses, data in order.
REQ-035 reset pulsed after 3rd data bit of 0x81 -> no pulses; following frame 0x42 -> rx_data=0x42.
